scanout_channel: RTL and testbench

- Parametrised, single-channel display scanout engine; the next generation of the per-screen path behind the framebuffer and screen driver.
- Generates programmable video timing from a pixel-enable divider and issues framebuffer read addresses with integer pixel replication.
- Expands 4-bit colour indices through a writable palette and selects between two framebuffer pages at frame boundaries.
- One instance is used per physical display (VGA, LCD); the top level instantiates N of them.

---
 rtl/scanout_channel.sv | 142 ++++++++++++++
 tb/tb_scanout_channel.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/scanout_channel.sv
// Single-channel display scanout: programmable video timing, replicated framebuffer
// addressing, palette expansion and frame-boundary page selection.
module scanout_channel #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned SCALE    = 2,
    parameter int unsigned ADDR_W   = 19,
    parameter int unsigned IDX_W    = 4,
    parameter int unsigned COLOR_W  = 5,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   buf_sel_req,
    output logic [ADDR_W-1:0]      fb_addr,
    input  logic [IDX_W-1:0]       fb_data,
    input  logic                   pal_we,
    input  logic [IDX_W-1:0]       pal_waddr,
    input  logic [3*COLOR_W-1:0]   pal_wdata,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   de,
    output logic [COLOR_W-1:0]     red,
    output logic [COLOR_W-1:0]     green,
    output logic [COLOR_W-1:0]     blue,
    output logic                   frame_start,
    output logic                   buf_active
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_W     = $clog2(H_TOTAL);
    localparam int unsigned V_W     = $clog2(V_TOTAL);
    localparam int unsigned DIV_W   = $clog2(CLK_DIV);
    localparam int unsigned FB_W    = H_ACTIVE / SCALE;
    localparam int unsigned FB_H    = V_ACTIVE / SCALE;
    localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
    localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;

    logic [DIV_W-1:0]       div_q;
    logic [H_W-1:0]         h_q;
    logic [V_W-1:0]         v_q;
    logic                   meta_hs_q, meta_vs_q, meta_de_q;
    logic [3*COLOR_W-1:0]   pal_q;
    logic [3*COLOR_W-1:0]   pal_mem [2**IDX_W];

    logic                   tick, h_last, v_last, active, hs_on, vs_on;
    logic [ADDR_W-1:0]      addr_next;

    always_comb begin
        tick      = enable && (div_q == '0);
        h_last    = 32'(h_q) == H_TOTAL - 1;
        v_last    = 32'(v_q) == V_TOTAL - 1;
        active    = (32'(h_q) < H_ACTIVE) && (32'(v_q) < V_ACTIVE);
        hs_on     = (32'(h_q) >= HS_BEG) && (32'(h_q) < HS_BEG + H_SYNC);
        vs_on     = (32'(v_q) >= VS_BEG) && (32'(v_q) < VS_BEG + V_SYNC);
        addr_next = (buf_active ? ADDR_W'(FB_W * FB_H) : '0)
                  + ADDR_W'(32'(v_q) / SCALE) * ADDR_W'(FB_W)
                  + ADDR_W'(32'(h_q) / SCALE);
    end

    // Palette storage is deliberately left unreset; a same-clock write returns the old entry.
    always_ff @(posedge clock) begin
        if (pal_we) begin
            pal_mem[pal_waddr] <= pal_wdata;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_q       <= '0;
            h_q         <= '0;
            v_q         <= '0;
            fb_addr     <= '0;
            buf_active  <= 1'b0;
            meta_hs_q   <= 1'b0;
            meta_vs_q   <= 1'b0;
            meta_de_q   <= 1'b0;
            pal_q       <= '0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            de          <= 1'b0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            frame_start <= 1'b0;
        end else if (!enable) begin
            div_q       <= '0;
            h_q         <= '0;
            v_q         <= '0;
            meta_hs_q   <= 1'b0;
            meta_vs_q   <= 1'b0;
            meta_de_q   <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            de          <= 1'b0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            div_q       <= (32'(div_q) == CLK_DIV - 1) ? '0 : div_q + 1'b1;
            // fb_data for the address issued on the tick is valid two clocks later
            if (div_q == DIV_W'(2)) begin
                pal_q <= pal_mem[fb_data];
            end
            if (tick) begin
                if (active) begin
                    fb_addr <= addr_next;
                end
                meta_hs_q   <= hs_on;
                meta_vs_q   <= vs_on;
                meta_de_q   <= active;
                hsync       <= meta_hs_q ? SYNC_POL : ~SYNC_POL;
                vsync       <= meta_vs_q ? SYNC_POL : ~SYNC_POL;
                de          <= meta_de_q;
                {red, green, blue} <= meta_de_q ? pal_q : '0;
                frame_start <= (h_q == '0) && (v_q == '0);
                if (h_last) begin
                    h_q <= '0;
                    v_q <= v_last ? '0 : v_q + 1'b1;
                    // Page swap lands exactly at the start of vertical blanking
                    if (32'(v_q) == V_ACTIVE - 1) begin
                        buf_active <= buf_sel_req;
                    end
                end else begin
                    h_q <= h_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_scanout_channel.sv
// Directed bench: a small-geometry channel checked every clock against a timing model,
// plus a default-geometry channel for line timing and address spot checks.
module tb_scanout_channel;

    localparam int D = 3, HT = 16, VT = 10, FR = 160, HA = 8, VA = 6;

    logic        clock = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0, en_d = 1'b0;
    logic        buf_sel_req = 1'b0;
    logic [7:0]  fb_addr;
    logic [3:0]  fb_data;
    logic        pal_we = 1'b0;
    logic [3:0]  pal_waddr = '0;
    logic [14:0] pal_wdata = '0;
    logic        hsync, vsync, de, frame_start, buf_active;
    logic [4:0]  red, green, blue;

    logic [18:0] fb_addr_d;
    logic [3:0]  zero_idx = '0;
    logic [14:0] zero_col = '0;
    logic        hsync_d, vsync_d, de_d, fs_d, buf_d;
    logic [4:0]  red_d, green_d, blue_d;

    int checks = 0, errors = 0;
    int n_en, cyc = 0, last_fs = -1, fs_count = 0;
    logic exp_buf, fb_const = 1'b0, sb_on = 1'b0;
    logic [14:0] pal_model [16];

    always #5 clock = ~clock;

    scanout_channel #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .CLK_DIV(3), .SCALE(2), .ADDR_W(8), .IDX_W(4), .COLOR_W(5), .SYNC_POL(1'b0)
    ) dut (
        .clock(clock), .reset(rst), .enable(enable), .buf_sel_req(buf_sel_req),
        .fb_addr(fb_addr), .fb_data(fb_data), .pal_we(pal_we), .pal_waddr(pal_waddr),
        .pal_wdata(pal_wdata), .hsync(hsync), .vsync(vsync), .de(de), .red(red),
        .green(green), .blue(blue), .frame_start(frame_start), .buf_active(buf_active)
    );

    scanout_channel dut_dflt (
        .clock(clock), .reset(rst), .enable(en_d), .buf_sel_req(1'b0),
        .fb_addr(fb_addr_d), .fb_data(zero_idx), .pal_we(1'b0), .pal_waddr(zero_idx),
        .pal_wdata(zero_col), .hsync(hsync_d), .vsync(vsync_d), .de(de_d), .red(red_d),
        .green(green_d), .blue(blue_d), .frame_start(fs_d), .buf_active(buf_d)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_addr(input int h, input int v, input logic b);
        return 8'((b ? 12 : 0) + (v / 2) * 4 + h / 2);
    endfunction

    // Framebuffer: synchronous read, one clock latency
    always @(posedge clock) fb_data <= fb_const ? 4'd3 : fb_addr[3:0];

    always @(posedge clock) cyc <= cyc + 1;

    // n_en counts enabled edges since enable rose; swap model samples on the (15,5) tick
    always @(posedge clock or posedge rst) begin
        if (rst) begin
            n_en    <= 0;
            exp_buf <= 1'b0;
        end else if (!enable) begin
            n_en <= 0;
        end else begin
            if (n_en % D == 0 && (n_en / D) % FR == 5 * HT + 15) exp_buf <= buf_sel_req;
            n_en <= n_en + 1;
        end
    end

    always @(negedge clock) begin
        if (n_en == 0) last_fs = -1;
        else if (frame_start) begin
            fs_count++;
            if (last_fs >= 0) check("fs_period", cyc - last_fs, FR * D);
            last_fs = cyc;
        end
    end

    always @(negedge clock) begin
        int e, k, h, v;
        logic de_e;
        logic [7:0] a;
        logic [14:0] col;
        if (sb_on) begin
            check("buf_active", buf_active, exp_buf);
            if (n_en == 0) begin
                check("idle_hsync", hsync, 1);
                check("idle_vsync", vsync, 1);
                check("idle_de", de, 0);
                check("idle_rgb", {red, green, blue}, 0);
                check("idle_fs", frame_start, 0);
            end else begin
                e = n_en - 1;
                k = e / D;
                check("frame_start", frame_start, (e % D == 0) && (k % FR == 0));
                h = k % HT;
                v = (k / HT) % VT;
                if (h < HA && v < VA) check("fb_addr", fb_addr, exp_addr(h, v, exp_buf));
                if (k == 0) begin
                    check("first_hsync", hsync, 1);
                    check("first_de", de, 0);
                end else begin
                    h = (k - 1) % HT;
                    v = ((k - 1) / HT) % VT;
                    de_e = (h < HA) && (v < VA);
                    a = exp_addr(h, v, exp_buf);
                    col = de_e ? pal_model[fb_const ? 4'd3 : a[3:0]] : 15'd0;
                    check("hsync", hsync, !(h >= 10 && h < 13));
                    check("vsync", vsync, !(v >= 7 && v < 9));
                    check("de", de, de_e);
                    check("rgb", {red, green, blue}, col);
                end
            end
        end
    end

    task automatic wait_n(input int target);
        for (int i = 0; i < 3000; i++) begin
            if (n_en == target) break;
            @(negedge clock);
        end
        check("wait_n", n_en, target);
    endtask

    task automatic pal_write(input logic [3:0] idx, input logic [14:0] val);
        @(negedge clock);
        pal_we = 1'b1;
        pal_waddr = idx;
        pal_wdata = val;
        @(negedge clock);
        pal_we = 1'b0;
        pal_model[idx] = val;
    endtask

    task automatic check_reset_state();
        check("rst_hsync", hsync, 1);
        check("rst_vsync", vsync, 1);
        check("rst_de", de, 0);
        check("rst_rgb", {red, green, blue}, 0);
        check("rst_fs", frame_start, 0);
        check("rst_buf", buf_active, 0);
        check("rst_addr", fb_addr, 0);
    endtask

    initial begin
        int fall1, fall2, rise1;
        logic hs_prev;
        fall1 = -1; fall2 = -1; rise1 = -1; hs_prev = 1'b1;
        repeat (3) @(negedge clock);
        check_reset_state();
        rst = 1'b0;

        // Default geometry: hsync placement, line period, address at (5,3) and (6,3)
        @(negedge clock);
        en_d = 1'b1;
        for (int c = 1; c <= 9625; c++) begin
            @(negedge clock);
            if (hs_prev && !hsync_d) begin
                if (fall1 < 0) fall1 = c;
                else if (fall2 < 0) fall2 = c;
            end
            if (!hs_prev && hsync_d && rise1 < 0) rise1 = c;
            hs_prev = hsync_d;
            if (c == 9621) check("dflt_addr_5_3", fb_addr_d, 322);
            if (c == 9625) check("dflt_addr_6_3", fb_addr_d, 323);
        end
        check("dflt_hs_fall", fall1, 2629);
        check("dflt_hs_width", rise1 - fall1, 96 * 4);
        check("dflt_line", fall2 - fall1, 3200);
        en_d = 1'b0;

        // Distinct palette so rgb reveals which address fed each pixel
        for (int i = 0; i < 16; i++) pal_write(4'(i), {5'(i), 5'(2 * i), 5'(31 - i)});

        sb_on = 1'b1;
        @(negedge clock);
        enable = 1'b1;
        wait_n(97);
        buf_sel_req = 1'b1;
        wait_n(285);
        check("swap_before", buf_active, 0);
        wait_n(286);
        check("swap_after", buf_active, 1);
        wait_n(500);
        buf_sel_req = 1'b0;
        wait_n(980);
        enable = 1'b0;
        @(negedge clock);
        check("drop_de", de, 0);
        check("drop_hsync", hsync, 1);
        repeat (4) @(negedge clock);
        enable = 1'b1;
        wait_n(1);
        check("reen_fs", frame_start, 1);
        check("reen_addr", fb_addr, 0);
        wait_n(4);
        check("reen_de", de, 1);

        // Constant index 3, then a write to entry 3 on the very clock it is read
        enable = 1'b0;
        pal_write(4'd3, 15'h7C00);
        fb_const = 1'b1;
        @(negedge clock);
        enable = 1'b1;
        wait_n(101);
        sb_on = 1'b0;
        pal_we = 1'b1;
        pal_waddr = 4'd3;
        pal_wdata = 15'h03E7;
        @(negedge clock);
        pal_we = 1'b0;
        wait_n(103);
        check("same_clk_old", {red, green, blue}, 15'h7C00);
        check("same_clk_de", de, 1);
        wait_n(106);
        check("same_clk_new", {red, green, blue}, 15'h03E7);
        pal_model[3] = 15'h03E7;
        sb_on = 1'b1;

        // Asynchronous reset at (5,3) of the second frame
        wait_n(640);
        sb_on = 1'b0;
        #1 rst = 1'b1;
        #1 check_reset_state();
        @(negedge clock);
        @(negedge clock);
        fb_const = 1'b0;
        fs_count = 0;
        rst = 1'b0;
        sb_on = 1'b1;
        repeat (1000) @(negedge clock);
        check("post_rst_frames", fs_count, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
